// File: rtl/neo_spike_detector.sv
// Spike detector for the NEO energy stream: an EMA noise floor, a scaled threshold and refractory blanking.
// Define NEO_DET_PEAK_EN to add the ABOVE state, which tracks each event's peak energy and reports it on Peak/Peak_valid.
module neo_spike_detector #(
  parameter int          AVG_SHIFT = 3,
  parameter int          THR_MULT  = 4,
  parameter logic [15:0] THR_MIN   = 16'd16,
  parameter int          WARMUP    = 8,
  parameter int          REFRACT   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Enable,
  input  logic signed [15:0] Data_in,
  output logic               Spike,
  output logic        [15:0] Threshold,
  output logic        [15:0] Spike_count,
  output logic        [15:0] Peak,
  output logic               Peak_valid
);

  localparam logic [1:0] ST_WARMUP  = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
`ifdef NEO_DET_PEAK_EN
  localparam logic [1:0] ST_ABOVE   = 2'd2;
`endif
  localparam logic [1:0] ST_REFRACT = 2'd3;

  localparam logic [7:0]  WARM_LAST = 8'(WARMUP - 1);
  localparam logic [15:0] RC_LOAD   = 16'(REFRACT);

  logic [1:0]  state_q, state_d;
  logic [14:0] avg_q, avg_d;
  logic [15:0] thr_q, thr_d;
  logic [7:0]  wc_q, wc_d;
  logic [15:0] rc_q, rc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        spike_q, spike_d;
`ifdef NEO_DET_PEAK_EN
  logic [14:0] pk_q, pk_d;
  logic [15:0] peak_q, peak_d;
  logic        pv_q, pv_d;
`endif

  logic [14:0]        x;
  logic signed [16:0] diff;
  logic signed [16:0] step;
  logic signed [16:0] sum;
  logic [14:0]        avg_ema;
  logic               unused_sum_bits;
  logic [19:0]        prod;
  logic [15:0]        capped;
  logic               above;

  // Negative energy is clamped to zero, so everything downstream is unsigned 15-bit.
  assign x    = Data_in[15] ? 15'd0 : Data_in[14:0];
  assign diff = $signed({2'b00, x}) - $signed({2'b00, avg_q});
  assign step = diff >>> AVG_SHIFT;
  assign sum  = $signed({2'b00, avg_q}) + step;
  assign avg_ema = sum[14:0];
  assign unused_sum_bits = ^sum[16:15];

  assign prod   = {5'd0, avg_q} * 20'(THR_MULT);
  assign capped = (prod > 20'h07FFF) ? 16'h7FFF : prod[15:0];
  assign thr_d  = (capped < THR_MIN) ? THR_MIN : capped;

  assign above = {1'b0, x} > thr_q;

  always_comb begin
    state_d = state_q;
    avg_d   = avg_q;
    wc_d    = wc_q;
    rc_d    = rc_q;
    cnt_d   = cnt_q;
    spike_d = 1'b0;
`ifdef NEO_DET_PEAK_EN
    pk_d    = pk_q;
    peak_d  = peak_q;
    pv_d    = 1'b0;
`endif
    if (Enable) begin
      case (state_q)
        ST_WARMUP: begin
          avg_d = avg_ema;
          if (wc_q == WARM_LAST) begin
            wc_d    = 8'd0;
            state_d = ST_IDLE;
          end else begin
            wc_d = wc_q + 8'd1;
          end
        end
        ST_IDLE: begin
          // The detection sample never enters the floor estimate.
          if (above) begin
            spike_d = 1'b1;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
`ifdef NEO_DET_PEAK_EN
            pk_d    = x;
            state_d = ST_ABOVE;
`else
            if (REFRACT != 0) begin
              rc_d    = RC_LOAD;
              state_d = ST_REFRACT;
            end
`endif
          end else begin
            avg_d = avg_ema;
          end
        end
`ifdef NEO_DET_PEAK_EN
        ST_ABOVE: begin
          if (above) begin
            if (x > pk_q) pk_d = x;
          end else begin
            peak_d = {1'b0, pk_q};
            pv_d   = 1'b1;
            if (REFRACT != 0) begin
              rc_d    = RC_LOAD;
              state_d = ST_REFRACT;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
`endif
        ST_REFRACT: begin
          // The sample that finds rc at 1 is the last blanked one.
          avg_d = avg_ema;
          if (rc_q <= 16'd1) begin
            state_d = ST_IDLE;
          end else begin
            rc_d = rc_q - 16'd1;
          end
        end
        default: state_d = ST_WARMUP;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_WARMUP;
      avg_q   <= 15'd0;
      thr_q   <= 16'd0;
      wc_q    <= 8'd0;
      rc_q    <= 16'd0;
      cnt_q   <= 16'd0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      avg_q   <= avg_d;
      thr_q   <= thr_d;
      wc_q    <= wc_d;
      rc_q    <= rc_d;
      cnt_q   <= cnt_d;
      spike_q <= spike_d;
    end
  end

`ifdef NEO_DET_PEAK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pk_q   <= 15'd0;
      peak_q <= 16'd0;
      pv_q   <= 1'b0;
    end else begin
      pk_q   <= pk_d;
      peak_q <= peak_d;
      pv_q   <= pv_d;
    end
  end

  assign Peak       = peak_q;
  assign Peak_valid = pv_q;
`else
  assign Peak       = 16'd0;
  assign Peak_valid = 1'b0;
`endif

  assign Spike       = spike_q;
  assign Threshold   = thr_q;
  assign Spike_count = cnt_q;

endmodule
